// File: rtl/cpa_rr_arbiter.sv
// Round-robin arbitrated access to one shared carry-propagate adder.
// One requester is accepted per cycle; its registered sum is returned with its
// ID over a valid/ready channel. A saturating counter tracks accepted requests.

// Plain carry-propagate adder; any carry out of the top bit is dropped.
module CPA_module #(
  parameter int BITS = 40
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum
);
  assign sum = a + b + {{(BITS-1){1'b0}}, cin};
endmodule

module cpa_rr_arbiter #(
  parameter int BITS  = 40,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [BITS-1:0]      res_data,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready,
  output logic [CNT_W-1:0]     txn_cnt
);
  localparam int PTR_W = $clog2(NREQ);
  // One spare bit so rr_ptr + offset can exceed NREQ before wrapping.
  localparam int CW    = PTR_W + 1;

  if (NREQ < 2 || NREQ > 16) begin : g_nreq_chk
    $error("cpa_rr_arbiter: NREQ must be in 2..16");
  end
  if ((1 << ID_W) < NREQ) begin : g_idw_chk
    $error("cpa_rr_arbiter: ID_W too narrow for NREQ");
  end

  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] grant_idx_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic [CW-1:0]    cand_s;
  logic             grant_found_s;
  logic             accept_en_s;
  logic             accept_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [BITS-1:0]  op_a_s;
  logic [BITS-1:0]  op_b_s;
  logic [BITS-1:0]  sum_s;
  logic             res_valid_r;
  logic [BITS-1:0]  res_data_r;
  logic [ID_W-1:0]  res_id_r;
  logic [CNT_W-1:0] txn_cnt_r;

  // Find the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + CW'(k);
      if (cand_s >= CW'(NREQ)) begin
        cand_s = cand_s - CW'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[PTR_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A slot is free when the result register is empty or is being drained;
  // nothing is accepted while reset is asserted.
  assign accept_en_s = !res_valid_r || res_ready;
  assign accept_s    = rst_n && accept_en_s && grant_found_s;

  // One-hot acceptance strobe for the granted requester.
  always_comb begin
    if (accept_s) begin
      req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Operand mux and pointer successor for the granted requester.
  always_comb begin
    op_a_s = req_a[int'(grant_idx_s)*BITS +: BITS];
    op_b_s = req_b[int'(grant_idx_s)*BITS +: BITS];
    if (grant_idx_s == PTR_W'(NREQ-1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + PTR_W'(1);
    end
  end

  CPA_module #(.BITS(BITS)) u_cpa (
    .a   (op_a_s),
    .b   (op_b_s),
    .cin (1'b0),
    .sum (sum_s)
  );

  // Result register and round-robin pointer: load on accept, clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= '0;
      rr_ptr_r    <= '0;
    end else if (accept_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= sum_s;
      res_id_r    <= ID_W'(grant_idx_s);
      rr_ptr_r    <= next_ptr_s;
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  // Saturating count of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_r <= '0;
    end else if (accept_s && (txn_cnt_r != {CNT_W{1'b1}})) begin
      txn_cnt_r <= txn_cnt_r + CNT_W'(1);
    end else begin
      txn_cnt_r <= txn_cnt_r;
    end
  end

  assign req_ready = req_ready_s;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign txn_cnt   = txn_cnt_r;
endmodule

// File: doc/cpa_rr_arbiter.md
Name: cpa_rr_arbiter

Overview:
Shares one BITS-wide carry-propagate adder (a single CPA_module instance) between NREQ requesters, such as the partial-product reduction trees of several multiplier lanes. A round-robin arbiter selects one request per cycle and feeds its operand pair to the adder. The sum is registered, then returned with the requester's ID over a valid/ready result channel that supports backpressure. A saturating transaction counter is provided for performance monitoring.

Parameters:
BITS, 40, operand and sum width; passed to the CPA_module instance.
NREQ, 4, number of requesters; legal range 2..16.
ID_W, 2, result ID width; 2**ID_W >= NREQ is required (static check).
CNT_W, 16, width of the transaction counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  bit i set = requester i presents operands.
req_a  input  NREQ*BITS  operand A of requester i at [i*BITS +: BITS].
req_b  input  NREQ*BITS  operand B of requester i at [i*BITS +: BITS].
req_ready  output  NREQ  one-hot acceptance; bit i high = requester i accepted this cycle.
res_valid  output  1  result register holds a valid sum.
res_data  output  BITS  registered sum, (a + b) mod 2**BITS.
res_id  output  ID_W  index of the requester that produced res_data.
res_ready  input  1  consumer accepts the result when high together with res_valid.
txn_cnt  output  CNT_W  count of accepted requests; saturates at all-ones.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally): res_valid=0, res_data=0, res_id=0, txn_cnt=0, rr_ptr=0. req_ready is 0 while rst_n=0.
- accept_en = !res_valid || res_ready. Full throughput is one result per cycle while res_ready=1.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, then rr_ptr+1, and so on, modulo NREQ.
  - The first set bit is the grant g.
  - req_ready = onehot(g) when accept_en and |req_valid; otherwise 0.
  - req_ready may depend combinationally on req_valid and res_ready. It must never depend on req_a or req_b.
- On accept (|req_ready at a clock edge):
  - res_data <= CPA sum of req_a[g] and req_b[g]. The CPA carry-in is 0 and the carry-out is discarded, so the sum wraps modulo 2**BITS.
  - res_id <= g; res_valid <= 1.
  - rr_ptr <= (g+1) mod NREQ, wrapping from NREQ-1 to 0.
  - txn_cnt increments unless it is all-ones.
- Latency: the result is visible one cycle after the accepting edge. The CPA sits combinationally between the operand mux and the result register.
- Result drain without a new accept (res_valid and res_ready, no request): res_valid <= 0. res_data and res_id hold their old values.
- Stall (res_valid and !res_ready):
  - res_valid, res_data, res_id and rr_ptr hold.
  - All req_ready bits are 0.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1, with no bubble.
- No request: rr_ptr holds. A lone requester is granted every cycle regardless of rr_ptr.
- Requester protocol: once req_valid[i] rises, it and its operands stay stable until req_ready[i]. A violation is a requester error; the arbiter has no obligation to detect it.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- Reset mid-operation: any pending result is discarded and not replayed. Arbitration restarts from requester 0.

Test Plan:
- Single request: requester 2, a=5, b=7, res_ready=1. Expected: req_ready=4'b0100 in the request cycle; next cycle res_valid=1, res_data=12, res_id=2; txn_cnt=1.
- Full contention: all 4 valid for 8 cycles with res_ready=1. Expected: grant order 0,1,2,3,0,1,2,3; one result per cycle; txn_cnt=8.
- Pointer skip: grant 2, then only requesters 1 and 3 valid. Expected: next grant 3, then 1, then rr_ptr=2.
- Backpressure: result for ID 0 pending with res_ready=0 for 3 cycles while requester 1 is valid. Expected: req_ready=0 for those cycles and res_data/res_id held. When res_ready=1, requester 1 is accepted in that same cycle with no bubble.
- Wrap-around sum: a=2**40-1, b=1. Expected: res_data=0. Separately, a=b=2**39. Expected: res_data=0.
- Reset mid-operation: rst_n low for 1 cycle while res_valid=1 and requesters 1 and 3 are valid. Expected: immediately res_valid=0, txn_cnt=0 and req_ready=0; after release, the first grant goes to requester 1 (search from rr_ptr=0).
